// File: rtl/seven_seg_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_bcd_display
// Brief    : NUM_DIGITS seven-segment driver: sequential double-dabble number
//            display or run-state status text with PAUSE blinking.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_bcd_display #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    pause_i,
    input  logic                    finish_i,
    input  logic                    mode_i,
    input  logic [VAL_W-1:0]        value_i,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic                    busy_o,
    output logic                    ovf_o
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam int          c_BCD_W   = 4 * NUM_DIGITS;
    localparam int          c_CNT_W   = $clog2(VAL_W + 1);
    localparam int          c_BLK_W   = $clog2(BLINK_DIV + 1);
    localparam logic [63:0] c_MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    localparam logic [6:0] c_SEG_DASH = 7'b0111111;
    localparam logic [6:0] c_SEG_DARK = 7'b1111111;
    localparam logic [6:0] c_SEG_G    = 7'b1000010;
    localparam logic [6:0] c_SEG_D    = 7'b0100001;
    localparam logic [6:0] c_SEG_O    = 7'b0100011;
    localparam logic [6:0] c_SEG_N    = 7'b0101011;
    localparam logic [6:0] c_SEG_E    = 7'b0000110;
    localparam logic [6:0] c_SEG_P    = 7'b0001100;
    localparam logic [6:0] c_SEG_A    = 7'b0001000;
    localparam logic [6:0] c_SEG_U    = 7'b1000001;
    localparam logic [6:0] c_SEG_S    = 7'b0010010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GO    = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1011000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return c_SEG_DARK;
        endcase
    endfunction

    // Text is right-aligned: k counts characters from the right end of the word.
    function automatic logic [6:0] status_char(input state_t st, input int k, input logic vis);
        logic [6:0] c;
        c = c_SEG_DARK;
        case (st)
            S_IDLE: c = c_SEG_DASH;
            S_GO: begin
                if (k == 0)      c = c_SEG_O;
                else if (k == 1) c = c_SEG_G;
            end
            S_PAUSE: begin
                if (vis) begin
                    if (k == 0)      c = c_SEG_E;
                    else if (k == 1) c = c_SEG_S;
                    else if (k == 2) c = c_SEG_U;
                    else if (k == 3) c = c_SEG_A;
                    else if (k == 4) c = c_SEG_P;
                end
            end
            S_DONE: begin
                if (k == 0)      c = c_SEG_E;
                else if (k == 1) c = c_SEG_N;
                else if (k == 2) c = c_SEG_O;
                else if (k == 3) c = c_SEG_D;
            end
            default: c = c_SEG_DARK;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Double-dabble converter
    // ------------------------------------------------------------------------
    logic                r_busy;
    logic                r_force;
    logic                r_valid;
    logic                r_ovf;
    logic                r_ovf_pend;
    logic [VAL_W-1:0]    r_last;
    logic [VAL_W-1:0]    r_shift;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [c_BCD_W-1:0]  r_digits;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [c_BCD_W-1:0]  w_bcd_adj;
    logic [c_BCD_W-1:0]  w_bcd_next;
    logic                w_sample;
    logic                w_last_iter;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    assign w_bcd_next  = {w_bcd_adj[c_BCD_W-2:0], r_shift[VAL_W-1]};
    assign w_last_iter = (r_cnt == c_CNT_W'(VAL_W - 1));
    assign w_sample    = !r_busy && (r_force || (value_i != r_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_force    <= 1'b1;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_last     <= '0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_digits   <= '0;
            r_cnt      <= '0;
        end else if (w_sample) begin
            r_busy     <= 1'b1;
            r_force    <= 1'b0;
            r_last     <= value_i;
            r_shift    <= value_i;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (64'(value_i) > c_MAX_VAL);
        end else if (r_busy) begin
            r_bcd   <= w_bcd_next;
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last_iter) begin
                // Digits and overflow flag switch together so no torn value is shown.
                r_busy   <= 1'b0;
                r_valid  <= 1'b1;
                r_digits <= w_bcd_next;
                r_ovf    <= r_ovf_pend;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run-state FSM with PAUSE blink timer
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_visible;
    logic [c_BLK_W-1:0]  r_blk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_visible <= 1'b1;
            r_blk_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) r_state <= S_GO;
                end
                S_GO: begin
                    if (pause_i) begin
                        r_state   <= S_PAUSE;
                        r_visible <= 1'b1;
                        r_blk_cnt <= '0;
                    end else if (finish_i) begin
                        r_state <= S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (pause_i) begin
                        r_state <= S_GO;
                    end else if (r_blk_cnt == c_BLK_W'(BLINK_DIV - 1)) begin
                        r_blk_cnt <= '0;
                        r_visible <= ~r_visible;
                    end else begin
                        r_blk_cnt <= r_blk_cnt + c_BLK_W'(1);
                    end
                end
                S_DONE: begin
                    if (start_i) r_state <= S_GO;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Display mux
    // ------------------------------------------------------------------------
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [7*NUM_DIGITS-1:0] w_hex_next;
    logic                    w_lead;

    always_comb begin
        w_hex_next = '1;
        w_lead     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (mode_i) begin
                w_hex_next[7*k +: 7] = status_char(r_state, k, r_visible);
            end else if (!r_valid) begin
                // Nothing converted yet since reset: keep the number display dark.
                w_hex_next[7*k +: 7] = c_SEG_DARK;
            end else if (r_ovf) begin
                w_hex_next[7*k +: 7] = c_SEG_DASH;
            end else begin
                if ((r_digits[4*k +: 4] != 4'd0) || (k == 0)) w_lead = 1'b0;
                w_hex_next[7*k +: 7] = w_lead ? c_SEG_DARK : seg_digit(r_digits[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_hex <= '1;
        else     r_hex <= w_hex_next;
    end

    assign hex_o  = r_hex;
    assign busy_o = r_busy;
    assign ovf_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_bcd_display
// Brief    : Directed self-checking bench for seven_seg_bcd_display (4 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_bcd_display;

    localparam logic [6:0] c_DK = 7'b1111111;
    localparam logic [6:0] c_DS = 7'b0111111;
    localparam logic [6:0] c_D0 = 7'b1000000;
    localparam logic [6:0] c_D1 = 7'b1111001;
    localparam logic [6:0] c_D2 = 7'b0100100;
    localparam logic [6:0] c_D3 = 7'b0110000;
    localparam logic [6:0] c_D4 = 7'b0011001;
    localparam logic [6:0] c_D5 = 7'b0010010;
    localparam logic [6:0] c_D7 = 7'b1011000;
    localparam logic [6:0] c_D9 = 7'b0010000;
    localparam logic [6:0] c_LG = 7'b1000010;
    localparam logic [6:0] c_Ld = 7'b0100001;
    localparam logic [6:0] c_Lo = 7'b0100011;
    localparam logic [6:0] c_Ln = 7'b0101011;
    localparam logic [6:0] c_LE = 7'b0000110;
    localparam logic [6:0] c_LA = 7'b0001000;
    localparam logic [6:0] c_LU = 7'b1000001;
    localparam logic [6:0] c_LS = 7'b0010010;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, pause_i, finish_i, mode_i;
    logic [13:0] value_i;
    logic [27:0] hex_o;
    logic        busy_o, ovf_o;

    int n_cmp  = 0;
    int n_fail = 0;

    seven_seg_bcd_display #(
        .NUM_DIGITS (4),
        .VAL_W      (14),
        .BLINK_DIV  (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .pause_i  (pause_i),
        .finish_i (finish_i),
        .mode_i   (mode_i),
        .value_i  (value_i),
        .hex_o    (hex_o),
        .busy_o   (busy_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Applies a value and waits until its result has reached hex_o.
    task automatic apply_value(input logic [13:0] val, output int busy_n);
        value_i = val;
        busy_n  = 0;
        repeat (16) begin
            tick(1);
            if (busy_o) busy_n++;
        end
    endtask

    task automatic test_reset();
        logic [27:0] exp;
        rst = 1'b1; start_i = 1'b0; pause_i = 1'b0; finish_i = 1'b0;
        mode_i = 1'b0; value_i = 14'd0;
        tick(2);
        n_cmp++; if (hex_o !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_hex got %h want %h", hex_o, 28'hFFFFFFF); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
        rst = 1'b0;
        tick(1);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL forced_busy_rise got %b want 1", busy_o); end
        tick(13);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL forced_busy_last got %b want 1", busy_o); end
        tick(1);
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL forced_busy_fall got %b want 0", busy_o); end
        n_cmp++; if (hex_o !== 28'hFFFFFFF) begin n_fail++; $display("FAIL forced_early got %h want %h", hex_o, 28'hFFFFFFF); end
        tick(1);
        exp = {c_DK, c_DK, c_DK, c_D0};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL forced_zero got %h want %h", hex_o, exp); end
    endtask

    task automatic test_number();
        logic [27:0] exp;
        int          busy_n;
        apply_value(14'd1234, busy_n);
        n_cmp++; if (busy_n !== 14) begin n_fail++; $display("FAIL busy_len got %0d want 14", busy_n); end
        exp = {c_D1, c_D2, c_D3, c_D4};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL num_1234 got %h want %h", hex_o, exp); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_1234 got %b want 0", ovf_o); end
        apply_value(14'd305, busy_n);
        exp = {c_DK, c_D3, c_D0, c_D5};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL num_305 got %h want %h", hex_o, exp); end
    endtask

    task automatic test_busy_ignore();
        logic [27:0] exp7, exp9;
        exp7 = {c_DK, c_DK, c_DK, c_D7};
        exp9 = {c_DK, c_DK, c_DK, c_D9};
        value_i = 14'd7;
        tick(3);
        value_i = 14'd9;
        tick(13);
        n_cmp++; if (hex_o !== exp7) begin n_fail++; $display("FAIL busy_first7 got %h want %h", hex_o, exp7); end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL resample_busy got %b want 1", busy_o); end
        tick(14);
        n_cmp++; if (hex_o !== exp7) begin n_fail++; $display("FAIL hold7 got %h want %h", hex_o, exp7); end
        tick(1);
        n_cmp++; if (hex_o !== exp9) begin n_fail++; $display("FAIL then9 got %h want %h", hex_o, exp9); end
    endtask

    task automatic test_overflow();
        logic [27:0] exp;
        int          busy_n;
        apply_value(14'd10000, busy_n);
        exp = {c_DS, c_DS, c_DS, c_DS};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL ovf_dash got %h want %h", hex_o, exp); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_10000 got %b want 1", ovf_o); end
        apply_value(14'd9999, busy_n);
        exp = {c_D9, c_D9, c_D9, c_D9};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL num_9999 got %h want %h", hex_o, exp); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_9999 got %b want 0", ovf_o); end
    endtask

    task automatic test_status();
        logic [27:0] exp, exp_go, exp_pause, exp_done;
        exp_go    = {c_DK, c_DK, c_LG, c_Lo};
        exp_pause = {c_LA, c_LU, c_LS, c_LE};
        exp_done  = {c_Ld, c_Lo, c_Ln, c_LE};
        mode_i = 1'b1;
        tick(1);
        exp = {c_DS, c_DS, c_DS, c_DS};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL idle_dash got %h want %h", hex_o, exp); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mode_no_conv got %b want 0", busy_o); end
        start_i = 1'b1; tick(1); start_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_go) begin n_fail++; $display("FAIL go_text got %h want %h", hex_o, exp_go); end
        pause_i = 1'b1; tick(1); pause_i = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            exp = (((i - 1) / 4) % 2 == 0) ? exp_pause : 28'hFFFFFFF;
            n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL blink_%0d got %h want %h", i, hex_o, exp); end
        end
        pause_i = 1'b1; tick(1); pause_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_go) begin n_fail++; $display("FAIL unpause_go got %h want %h", hex_o, exp_go); end
        pause_i = 1'b1; finish_i = 1'b1; tick(1); pause_i = 1'b0; finish_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_pause) begin n_fail++; $display("FAIL pause_prio got %h want %h", hex_o, exp_pause); end
        finish_i = 1'b1; tick(1); finish_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_pause) begin n_fail++; $display("FAIL finish_in_pause got %h want %h", hex_o, exp_pause); end
        pause_i = 1'b1; tick(1); pause_i = 1'b0;
        finish_i = 1'b1; tick(1); finish_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_done) begin n_fail++; $display("FAIL done_text got %h want %h", hex_o, exp_done); end
        start_i = 1'b1; tick(1); start_i = 1'b0; tick(1);
        n_cmp++; if (hex_o !== exp_go) begin n_fail++; $display("FAIL restart_go got %h want %h", hex_o, exp_go); end
    endtask

    task automatic test_reset_midconv();
        logic [27:0] exp;
        mode_i = 1'b0;
        tick(1);
        value_i = 14'd1234;
        tick(1);
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy_o); end
        tick(4);
        rst = 1'b1;
        tick(1);
        n_cmp++; if (hex_o !== 28'hFFFFFFF) begin n_fail++; $display("FAIL mid_rst_hex got %h want %h", hex_o, 28'hFFFFFFF); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b want 0", ovf_o); end
        rst = 1'b0;
        tick(15);
        n_cmp++; if (hex_o !== 28'hFFFFFFF) begin n_fail++; $display("FAIL mid_early got %h want %h", hex_o, 28'hFFFFFFF); end
        tick(1);
        exp = {c_D1, c_D2, c_D3, c_D4};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL mid_1234 got %h want %h", hex_o, exp); end
        mode_i = 1'b1;
        tick(1);
        exp = {c_DS, c_DS, c_DS, c_DS};
        n_cmp++; if (hex_o !== exp) begin n_fail++; $display("FAIL rst_fsm_idle got %h want %h", hex_o, exp); end
    endtask

    initial begin
        test_reset();
        test_number();
        test_busy_ignore();
        test_overflow();
        test_status();
        test_reset_midconv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
